// File: rtl/panel_input.sv
// Front-panel input conditioning: synchronises and debounces six LED buttons plus the
// maintenance button, toggles per-LED enables on short presses and maintenance mode on a long hold.
module panel_input #(
    parameter int unsigned TICK_DIV       = 100000,
    parameter int unsigned DEBOUNCE_COUNT = 8,
    parameter int unsigned LONG_PRESS     = 2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] buttons,
    input  logic       mtne_button,
    output logic [5:0] led_enable,
    output logic       mtne_mode,
    output logic [5:0] press_pulse
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_COUNT + 1);
    localparam int unsigned HW = $clog2(LONG_PRESS + 1);
    localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DbLast   = DW'(DEBOUNCE_COUNT - 1);
    localparam logic [HW-1:0] HoldLast = HW'(LONG_PRESS - 1);

    typedef enum logic [1:0] {StIdle, StHeld, StWaitRelease} mtne_state_e;

    logic [6:0]          sync1_q, sync2_q;
    logic [TW-1:0]       tick_cnt_q;
    logic                tick;
    logic [6:0]          stable_q, stable_dly_q, stable_next;
    logic [6:0][DW-1:0]  db_cnt_q, db_cnt_next;
    logic [6:0]          press;
    mtne_state_e         state_q, state_next;
    logic [HW-1:0]       hold_q;
    logic                hold_clear, hold_inc, mode_toggle;
    logic [5:0]          led_q, pulse_q;
    logic                mode_q;

    assign tick  = (tick_cnt_q == TickLast);
    assign press = stable_q & ~stable_dly_q;

    // Counter advances only on ticks that still disagree; agreement restarts the count.
    always_comb begin
        stable_next = stable_q;
        db_cnt_next = db_cnt_q;
        if (tick) begin
            for (int i = 0; i < 7; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    db_cnt_next[i] = '0;
                end else if (db_cnt_q[i] == DbLast) begin
                    stable_next[i] = sync2_q[i];
                    db_cnt_next[i] = '0;
                end else begin
                    db_cnt_next[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        unique case (state_q)
            StIdle:        if (press[6]) state_next = StHeld;
            StHeld: begin
                if (!stable_q[6]) begin
                    state_next = StIdle;
                end else if (tick && hold_q == HoldLast) begin
                    state_next = StWaitRelease;
                end
            end
            StWaitRelease: if (!stable_q[6]) state_next = StIdle;
            default:       state_next = StIdle;
        endcase
    end

    always_comb begin
        hold_clear  = (state_q == StIdle) && press[6];
        hold_inc    = (state_q == StHeld) && stable_q[6] && tick;
        mode_toggle = hold_inc && (hold_q == HoldLast);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            tick_cnt_q   <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            db_cnt_q     <= '0;
            hold_q       <= '0;
            led_q        <= '0;
            pulse_q      <= '0;
            mode_q       <= 1'b0;
        end else begin
            sync1_q      <= {mtne_button, buttons};
            sync2_q      <= sync1_q;
            tick_cnt_q   <= tick ? '0 : tick_cnt_q + TW'(1);
            stable_q     <= stable_next;
            stable_dly_q <= stable_q;
            db_cnt_q     <= db_cnt_next;
            if (hold_clear) begin
                hold_q <= '0;
            end else if (hold_inc) begin
                hold_q <= hold_q + HW'(1);
            end
            pulse_q <= press[5:0];
            // Freeze uses the registered mode, so a same-clock mode toggle sees the old value.
            led_q   <= led_q ^ (press[5:0] & {6{~mode_q}});
            mode_q  <= mode_q ^ mode_toggle;
        end
    end

    assign led_enable  = led_q;
    assign mtne_mode   = mode_q;
    assign press_pulse = pulse_q;

endmodule

// File: doc/panel_input.md
# panel_input

Front-panel input block: samples six raw pushbuttons and one maintenance pushbutton, then synchronises and debounces them. It generates the `led_enable[5:0]` and `mtne_mode` controls consumed by the LED driver. Short presses toggle individual LED enables. A long press of the maintenance button toggles maintenance mode. It sits between the board pins and the LED control logic in the top level.

## Interface
- `TICK_DIV`, default 100000: clock cycles per debounce sample tick.
- `DEBOUNCE_COUNT`, default 8: consecutive disagreeing ticks required to accept a new input level.
- `LONG_PRESS`, default 2000: ticks the maintenance button must stay held to toggle `mtne_mode`.

- `clock`  input  1  system clock; the only clock in the block.
- `reset`  input  1  reset, asynchronous, active-low (held high when not in reset).
- `buttons`  input  6  raw pushbuttons, asynchronous, 1 = pressed.
- `mtne_button`  input  1  raw maintenance pushbutton, asynchronous, 1 = pressed.
- `led_enable`  output  6  registered per-LED enable state.
- `mtne_mode`  output  1  registered maintenance mode flag.
- `press_pulse`  output  6  one-clock pulse per accepted press of `buttons[i]`.

## Operation
- **Synchroniser:** all 7 raw inputs pass through a two-flop synchroniser, reset to 0.
- **Tick counter:**
  - Counts 0..`TICK_DIV`-1.
  - `tick` is high for one clock when the count equals `TICK_DIV`-1; the count then wraps to 0.
- **Debounce, per input (7 instances):**
  - State is a `stable` bit plus a counter of width clog2(`DEBOUNCE_COUNT`+1).
  - On a tick, if the synced input ≠ `stable`, the counter increments.
  - On a tick, if the synced input = `stable`, the counter clears.
  - When the increment would reach `DEBOUNCE_COUNT`, `stable` takes the synced value and the counter clears.
  - Non-tick cycles hold all state.
- **Edge detect:** `stable_d` is `stable` delayed one clock. A press is `stable & ~stable_d`.
- **Button press handling, for `buttons[i]`:**
  - `press_pulse[i]` goes high for exactly one clock, registered.
  - In the same cycle, `led_enable[i]` toggles, but only if `mtne_mode` is currently 0.
  - While `mtne_mode` = 1, `led_enable` is frozen but `press_pulse` still fires.
  - Presses on different buttons are independent. Simultaneous presses all act in the same cycle.
- **Maintenance FSM** (states IDLE, HELD, WAIT_RELEASE), with hold counter width clog2(`LONG_PRESS`+1):
  - IDLE: a debounced `mtne_button` press moves to HELD and clears the hold counter.
  - HELD, released (debounced) before the threshold: returns to IDLE; `mtne_mode` is unchanged.
  - HELD, held: the hold counter increments on each tick.
  - HELD, hold counter reaches `LONG_PRESS`: `mtne_mode` toggles on that clock and the FSM moves to WAIT_RELEASE.
  - WAIT_RELEASE: a debounced release returns to IDLE. There is no further toggle while held, and no auto-repeat.
- **Enable/mode ordering:** the `led_enable` freeze uses the registered `mtne_mode` value. If a button press and an `mtne_mode` toggle occur on the same clock, the enable toggle uses the pre-toggle mode.

## Timing
- **Reset (`reset`=0, asynchronous):**
  - `led_enable`=6'b000000, `mtne_mode`=0, `press_pulse`=0.
  - All synchroniser flops, `stable`, `stable_d`, the tick counter, the debounce counters and the hold counter = 0.
  - FSM = IDLE.
- **Mid-operation reset:**
  - Any debounce count or hold in progress is discarded.
  - An input still pressed at reset release is re-debounced and treated as a fresh press.
- **Latency, clean raw edge to `stable` change:** 2 synchroniser clocks plus `DEBOUNCE_COUNT` ticks. That is between (`DEBOUNCE_COUNT`-1)·`TICK_DIV`+3 and `DEBOUNCE_COUNT`·`TICK_DIV`+3 clocks, depending on tick phase.
- **Latency, `stable` rise to outputs:** `press_pulse` and the `led_enable` toggle follow 1 clock later.
- **Long-press toggle:** `mtne_mode` toggles exactly `LONG_PRESS` ticks after HELD is entered.
- **Bounce rejection:** a bounce shorter than `DEBOUNCE_COUNT` consecutive ticks produces no `stable` change.
- **Counter wrap:** the tick counter wraps freely. The hold counter never wraps, because the FSM leaves HELD at the threshold.

## Test plan
Bench parameters: `TICK_DIV`=4, `DEBOUNCE_COUNT`=3, `LONG_PRESS`=5.
- **Reset values:** assert `reset`=0 with all inputs high → all outputs 0 immediately (asynchronously). Release → outputs stay 0 until debounce completes.
- **Toggle on press:** hold `buttons[2]`=1 for 20 ticks, then release → one `press_pulse`=6'b000100, `led_enable`=6'b000100. A second press → `led_enable`=6'b000000.
- **Bounce rejection:** toggle `buttons[0]` every tick for 10 ticks, then hold 0 → no `press_pulse`, `led_enable` unchanged.
- **Maintenance FSM:**
  - Hold `mtne_button` for 3 ticks → `mtne_mode` stays 0.
  - Hold for ≥9 ticks → `mtne_mode`=1 exactly once. Holding 40 ticks → no further toggle.
  - With `mtne_mode`=1, press `buttons[1]` → `press_pulse[1]` fires, `led_enable` unchanged.
- **Simultaneous presses:** press `buttons[5]` and `buttons[3]` on the same clock → `press_pulse`=6'b101000 for one clock, `led_enable` bits 5 and 3 toggle together.
- **Reset mid-hold:** assert reset during HELD after 3 ticks → `mtne_mode`=0, FSM IDLE. Keep the button held → a fresh long press toggles `mtne_mode` to 1 after 5 further ticks post-debounce.
